// File: rtl/node_step_sequencer_if.sv
// Collision-stage handshake bundle between the node step sequencer and the
// collision stage.
//   master : sequencer side. Drives coll_begin_out and the issued node state,
//            and receives the result pulse and the returned fields.
//   slave  : collision-stage side, with the directions reversed.
interface node_step_sequencer_if #(
    parameter int unsigned POSITION_SIZE     = 8,
    parameter int unsigned VELOCITY_SIZE     = 8,
    parameter int unsigned ACCELERATION_SIZE = 3
);
    logic                         coll_begin_out;
    logic [POSITION_SIZE-1:0]     coll_pos_x_out;
    logic [POSITION_SIZE-1:0]     coll_pos_y_out;
    logic [VELOCITY_SIZE-1:0]     coll_vel_x_out;
    logic [VELOCITY_SIZE-1:0]     coll_vel_y_out;

    logic                         coll_result_in;
    logic [POSITION_SIZE-1:0]     coll_new_pos_x_in;
    logic [POSITION_SIZE-1:0]     coll_new_pos_y_in;
    logic [VELOCITY_SIZE-1:0]     coll_new_vel_x_in;
    logic [VELOCITY_SIZE-1:0]     coll_new_vel_y_in;
    logic [ACCELERATION_SIZE-1:0] coll_acc_x_in;
    logic [ACCELERATION_SIZE-1:0] coll_acc_y_in;

    modport master (
        output coll_begin_out, coll_pos_x_out, coll_pos_y_out,
               coll_vel_x_out, coll_vel_y_out,
        input  coll_result_in, coll_new_pos_x_in, coll_new_pos_y_in,
               coll_new_vel_x_in, coll_new_vel_y_in, coll_acc_x_in, coll_acc_y_in
    );

    modport slave (
        input  coll_begin_out, coll_pos_x_out, coll_pos_y_out,
               coll_vel_x_out, coll_vel_y_out,
        output coll_result_in, coll_new_pos_x_in, coll_new_pos_y_in,
               coll_new_vel_x_in, coll_new_vel_y_in, coll_acc_x_in, coll_acc_y_in
    );
endinterface

// File: rtl/node_step_sequencer.sv
// Owns the position/velocity state of every car node. It runs one physics step
// per begin_in by walking the nodes in order:
//   - gravity is applied to vel_y;
//   - the node is handed to the collision stage;
//   - the returned result is folded back into the node array.
// Ports:
//   clk_in, rst_in          : clock and synchronous active-low reset
//   begin_in                : start a step (accepted in IDLE only)
//   wr_en_in/wr_idx_in/wr_* : node write port (accepted in IDLE only)
//   coll                    : collision-stage handshake (master side)
//   pos_*_out, vel_*_out    : node state arrays
//   busy_out, done_out      : status; done_out pulses for one cycle per step
//   step_count_out          : completed steps, wraps at 16 bits
//   timeout_err_out         : sticky node-timeout flag
module node_step_sequencer #(
    parameter int unsigned NUM_NODES         = 8,
    parameter int unsigned POSITION_SIZE     = 8,
    parameter int unsigned VELOCITY_SIZE     = 8,
    parameter int unsigned ACCELERATION_SIZE = 3,
    parameter int          GRAVITY           = -1,
    parameter int unsigned TIMEOUT           = 64,
    localparam int unsigned IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    begin_in,
    input  logic                                    wr_en_in,
    input  logic [IDX_W-1:0]                        wr_idx_in,
    input  logic [POSITION_SIZE-1:0]                wr_pos_x_in,
    input  logic [POSITION_SIZE-1:0]                wr_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0]                wr_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0]                wr_vel_y_in,
    node_step_sequencer_if.master                   coll,
    output logic [NUM_NODES-1:0][POSITION_SIZE-1:0] pos_x_out,
    output logic [NUM_NODES-1:0][POSITION_SIZE-1:0] pos_y_out,
    output logic [NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_x_out,
    output logic [NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_y_out,
    output logic                                    busy_out,
    output logic                                    done_out,
    output logic [15:0]                             step_count_out,
    output logic                                    timeout_err_out
);
    localparam int unsigned P     = POSITION_SIZE;
    localparam int unsigned V     = VELOCITY_SIZE;
    localparam int unsigned A     = ACCELERATION_SIZE;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NODES - 1);
    localparam logic [IDX_W:0]   NODES     = (IDX_W + 1)'(NUM_NODES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [V:0]       GRAV_EXT  = (V + 1)'(GRAVITY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITEBACK,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] wait_cnt;

    logic             issue_load;
    logic             capture;
    logic             timeout_hit;

    logic [IDX_W-1:0] issue_idx;
    logic [P-1:0]     issue_pos_x;
    logic [P-1:0]     issue_pos_y;
    logic [V-1:0]     issue_vel_x;
    logic [V-1:0]     issue_vel_y_raw;
    logic             wr_in_range;

    logic [P-1:0]     cap_pos_x;
    logic [P-1:0]     cap_pos_y;
    logic [V-1:0]     cap_vel_x;
    logic [V-1:0]     cap_vel_y;
    logic [A-1:0]     cap_acc_x;
    logic [A-1:0]     cap_acc_y;

    // Clamp a V+1 bit sum back into the signed V-bit range.
    function automatic logic [V-1:0] sat(input logic [V:0] sum);
        if (sum[V] != sum[V-1]) begin
            sat = sum[V] ? {1'b1, {(V-1){1'b0}}} : {1'b0, {(V-1){1'b1}}};
        end else begin
            sat = sum[V-1:0];
        end
    endfunction

    function automatic logic [V:0] acc_ext(input logic [A-1:0] acc);
        acc_ext = {{(V + 1 - A){acc[A-1]}}, acc};
    endfunction

    assign wr_in_range = ({1'b0, wr_idx_in} < NODES);

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_d     = state;
        issue_load  = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (begin_in) begin
                    state_d    = S_ISSUE;
                    issue_load = 1'b1;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // A result on the last allowed cycle still beats the timeout.
                if (coll.coll_result_in) begin
                    state_d = S_WRITEBACK;
                    capture = 1'b1;
                end else if (wait_cnt == CNT_LIMIT) begin
                    state_d     = S_ADVANCE;
                    timeout_hit = 1'b1;
                end
            end
            S_WRITEBACK: state_d = S_ADVANCE;
            S_ADVANCE: begin
                if (idx == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_ISSUE;
                    issue_load = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Node data for the next issue. The coll_* registers load on entry to ISSUE,
    // so a write that lands together with begin_in is forwarded here.
    always_comb begin
        issue_idx = '0;
        if (state == S_ADVANCE) begin
            issue_idx = idx + IDX_W'(1);
        end
        issue_pos_x     = pos_x_out[issue_idx];
        issue_pos_y     = pos_y_out[issue_idx];
        issue_vel_x     = vel_x_out[issue_idx];
        issue_vel_y_raw = vel_y_out[issue_idx];
        if (state == S_IDLE && wr_en_in && wr_idx_in == '0) begin
            issue_pos_x     = wr_pos_x_in;
            issue_pos_y     = wr_pos_y_in;
            issue_vel_x     = wr_vel_x_in;
            issue_vel_y_raw = wr_vel_y_in;
        end
    end

    // Datapath: node array, collision outputs, capture and status registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pos_x_out           <= '0;
            pos_y_out           <= '0;
            vel_x_out           <= '0;
            vel_y_out           <= '0;
            coll.coll_begin_out <= 1'b0;
            coll.coll_pos_x_out <= '0;
            coll.coll_pos_y_out <= '0;
            coll.coll_vel_x_out <= '0;
            coll.coll_vel_y_out <= '0;
            idx                 <= '0;
            wait_cnt            <= '0;
            cap_pos_x           <= '0;
            cap_pos_y           <= '0;
            cap_vel_x           <= '0;
            cap_vel_y           <= '0;
            cap_acc_x           <= '0;
            cap_acc_y           <= '0;
            busy_out            <= 1'b0;
            done_out            <= 1'b0;
            step_count_out      <= '0;
            timeout_err_out     <= 1'b0;
        end else begin
            coll.coll_begin_out <= issue_load;
            busy_out            <= (state_d != S_IDLE);
            done_out            <= (state_d == S_DONE);

            if (state == S_IDLE && wr_en_in && wr_in_range) begin
                pos_x_out[wr_idx_in] <= wr_pos_x_in;
                pos_y_out[wr_idx_in] <= wr_pos_y_in;
                vel_x_out[wr_idx_in] <= wr_vel_x_in;
                vel_y_out[wr_idx_in] <= wr_vel_y_in;
            end

            if (issue_load) begin
                idx                 <= issue_idx;
                coll.coll_pos_x_out <= issue_pos_x;
                coll.coll_pos_y_out <= issue_pos_y;
                coll.coll_vel_x_out <= issue_vel_x;
                coll.coll_vel_y_out <= sat({issue_vel_y_raw[V-1], issue_vel_y_raw} + GRAV_EXT);
            end

            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (capture) begin
                cap_pos_x <= coll.coll_new_pos_x_in;
                cap_pos_y <= coll.coll_new_pos_y_in;
                cap_vel_x <= coll.coll_new_vel_x_in;
                cap_vel_y <= coll.coll_new_vel_y_in;
                cap_acc_x <= coll.coll_acc_x_in;
                cap_acc_y <= coll.coll_acc_y_in;
            end

            if (timeout_hit) begin
                timeout_err_out <= 1'b1;
            end

            if (state == S_WRITEBACK) begin
                pos_x_out[idx] <= cap_pos_x;
                pos_y_out[idx] <= cap_pos_y;
                vel_x_out[idx] <= sat({cap_vel_x[V-1], cap_vel_x} + acc_ext(cap_acc_x));
                vel_y_out[idx] <= sat({cap_vel_y[V-1], cap_vel_y} + acc_ext(cap_acc_y));
            end

            if (state_d == S_DONE) begin
                step_count_out <= step_count_out + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_node_step_sequencer.sv
// Self-checking bench for node_step_sequencer. A behavioural collision
// responder answers each issued node after a per-node delay taken from a table.
// An array-level model predicts issued values, final node state and step length.
module tb_node_step_sequencer;
    localparam int unsigned N    = 5;
    localparam int unsigned P    = 8;
    localparam int unsigned V    = 8;
    localparam int unsigned A    = 3;
    localparam int unsigned TO   = 64;
    localparam int unsigned IW   = 3;
    localparam int          GRAV = -1;

    logic clk = 1'b0;
    logic rst;
    logic begin_in;
    logic wr_en;
    logic [IW-1:0] wr_idx;
    logic [P-1:0] wr_px, wr_py;
    logic [V-1:0] wr_vx, wr_vy;
    logic [N-1:0][P-1:0] pos_x, pos_y;
    logic [N-1:0][V-1:0] vel_x, vel_y;
    logic busy, done, terr;
    logic [15:0] step_cnt;

    int total = 0;
    int bad = 0;

    node_step_sequencer_if #(.POSITION_SIZE(P), .VELOCITY_SIZE(V), .ACCELERATION_SIZE(A)) cif ();

    node_step_sequencer #(
        .NUM_NODES(N), .POSITION_SIZE(P), .VELOCITY_SIZE(V),
        .ACCELERATION_SIZE(A), .GRAVITY(GRAV), .TIMEOUT(TO)
    ) dut (
        .clk_in(clk), .rst_in(rst), .begin_in(begin_in), .wr_en_in(wr_en),
        .wr_idx_in(wr_idx), .wr_pos_x_in(wr_px), .wr_pos_y_in(wr_py),
        .wr_vel_x_in(wr_vx), .wr_vel_y_in(wr_vy), .coll(cif),
        .pos_x_out(pos_x), .pos_y_out(pos_y), .vel_x_out(vel_x), .vel_y_out(vel_y),
        .busy_out(busy), .done_out(done), .step_count_out(step_cnt),
        .timeout_err_out(terr)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int m_px[N], m_py[N], m_vx[N], m_vy[N];
    int m_cnt;
    bit m_err;

    // Responder tables: dly=0 means never answer.
    int dly[N], rnx[N], rny[N], rvx[N], rvy[N], rax[N], ray[N];
    int step_base = 0;
    int issue_total = 0;
    int pend = 0;
    int pend_node = 0;
    int lg_px[$], lg_py[$], lg_vx[$], lg_vy[$];

    function automatic int sat(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic int s8(input logic [7:0] x);
        return int'($signed(x));
    endfunction

    // Collision-stage stand-in: logs every begin pulse, answers after dly cycles.
    always @(negedge clk) begin
        cif.coll_result_in    = 1'b0;
        cif.coll_new_pos_x_in = '0;
        cif.coll_new_pos_y_in = '0;
        cif.coll_new_vel_x_in = '0;
        cif.coll_new_vel_y_in = '0;
        cif.coll_acc_x_in     = '0;
        cif.coll_acc_y_in     = '0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                cif.coll_result_in    = 1'b1;
                cif.coll_new_pos_x_in = P'(rnx[pend_node]);
                cif.coll_new_pos_y_in = P'(rny[pend_node]);
                cif.coll_new_vel_x_in = V'(rvx[pend_node]);
                cif.coll_new_vel_y_in = V'(rvy[pend_node]);
                cif.coll_acc_x_in     = A'(rax[pend_node]);
                cif.coll_acc_y_in     = A'(ray[pend_node]);
            end
        end
        if (cif.coll_begin_out === 1'b1) begin
            lg_px.push_back(s8(cif.coll_pos_x_out));
            lg_py.push_back(s8(cif.coll_pos_y_out));
            lg_vx.push_back(s8(cif.coll_vel_x_out));
            lg_vy.push_back(s8(cif.coll_vel_y_out));
            pend_node = issue_total - step_base;
            if (pend_node >= 0 && pend_node < int'(N)) pend = dly[pend_node];
            else pend = 0;
            issue_total = issue_total + 1;
        end
    end

    task automatic write_node(input int idx, input int px, input int py, input int vx, input int vy);
        wr_en = 1'b1; wr_idx = IW'(idx);
        wr_px = P'(px); wr_py = P'(py); wr_vx = V'(vx); wr_vy = V'(vy);
        @(negedge clk);
        wr_en = 1'b0;
        if (idx < int'(N)) begin
            m_px[idx] = px; m_py[idx] = py; m_vx[idx] = vx; m_vy[idx] = vy;
        end
    endtask

    task automatic random_resp(input int maxd);
        for (int i = 0; i < int'(N); i++) begin
            dly[i] = int'($urandom_range(1, maxd));
            rnx[i] = rnd8(); rny[i] = rnd8(); rvx[i] = rnd8(); rvy[i] = rnd8();
            rax[i] = int'($urandom_range(0, 7)) - 4;
            ray[i] = int'($urandom_range(0, 7)) - 4;
        end
    endtask

    // Runs one step against the model, optionally with a write alongside begin
    // and with random begin/write noise while the step is busy.
    task automatic run_step(input bit wr, input int widx, input int px, input int py,
                            input int vx, input int vy, input bit noise);
        int e_px[N], e_py[N], e_vx[N], e_vy[N];
        int exp_cyc, cyc, base;
        bit seen;
        base = issue_total;
        step_base = issue_total;
        if (wr && widx < int'(N)) begin
            m_px[widx] = px; m_py[widx] = py; m_vx[widx] = vx; m_vy[widx] = vy;
        end
        exp_cyc = 1;
        for (int i = 0; i < int'(N); i++) begin
            e_px[i] = m_px[i]; e_py[i] = m_py[i]; e_vx[i] = m_vx[i];
            e_vy[i] = sat(m_vy[i] + GRAV);
            if (dly[i] >= 1 && dly[i] <= int'(TO)) begin
                m_px[i] = rnx[i]; m_py[i] = rny[i];
                m_vx[i] = sat(rvx[i] + rax[i]); m_vy[i] = sat(rvy[i] + ray[i]);
                exp_cyc += 3 + dly[i];
            end else begin
                m_err = 1'b1;
                exp_cyc += int'(TO) + 2;
            end
        end
        m_cnt = (m_cnt + 1) % 65536;

        begin_in = 1'b1;
        if (wr) begin
            wr_en = 1'b1; wr_idx = IW'(widx);
            wr_px = P'(px); wr_py = P'(py); wr_vx = V'(vx); wr_vy = V'(vy);
        end
        @(negedge clk);
        begin_in = 1'b0; wr_en = 1'b0;
        cyc = 1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_step got %b want 1", busy); end
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (noise) begin
                    begin_in = 1'($urandom_range(0, 1));
                    wr_en = 1'($urandom_range(0, 1));
                    wr_idx = IW'($urandom_range(0, 7));
                    wr_px = P'(rnd8()); wr_py = P'(rnd8()); wr_vx = V'(rnd8()); wr_vy = V'(rnd8());
                end
                @(negedge clk);
                cyc++;
            end
        end
        begin_in = 1'b0; wr_en = 1'b0;
        total++;
        if (!seen) begin bad++; $display("FAIL step_done got none want pulse within 3000 cycles"); end
        total++;
        if (cyc !== exp_cyc) begin bad++; $display("FAIL step_latency got %0d want %0d", cyc, exp_cyc); end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_done got done=%b busy=%b want 0 0", done, busy);
        end
        total++;
        if (issue_total - base !== int'(N)) begin
            bad++; $display("FAIL begin_pulses got %0d want %0d", issue_total - base, N);
        end
        for (int i = 0; i < int'(N); i++) begin
            if (base + i < lg_px.size()) begin
                total++;
                if (lg_px[base+i] !== e_px[i] || lg_py[base+i] !== e_py[i] ||
                    lg_vx[base+i] !== e_vx[i] || lg_vy[base+i] !== e_vy[i]) begin
                    bad++;
                    $display("FAIL issue[%0d] got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)", i,
                             lg_px[base+i], lg_py[base+i], lg_vx[base+i], lg_vy[base+i],
                             e_px[i], e_py[i], e_vx[i], e_vy[i]);
                end
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            total++;
            if (s8(pos_x[i]) !== m_px[i] || s8(pos_y[i]) !== m_py[i] ||
                s8(vel_x[i]) !== m_vx[i] || s8(vel_y[i]) !== m_vy[i]) begin
                bad++;
                $display("FAIL node[%0d] got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)", i,
                         s8(pos_x[i]), s8(pos_y[i]), s8(vel_x[i]), s8(vel_y[i]),
                         m_px[i], m_py[i], m_vx[i], m_vy[i]);
            end
        end
        total++;
        if (int'(step_cnt) !== m_cnt) begin bad++; $display("FAIL step_count got %0d want %0d", step_cnt, m_cnt); end
        total++;
        if (terr !== m_err) begin bad++; $display("FAIL timeout_err got %b want %b", terr, m_err); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < int'(N); i++) begin
            m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
            total++;
            if (pos_x[i] !== '0 || pos_y[i] !== '0 || vel_x[i] !== '0 || vel_y[i] !== '0) begin
                bad++; $display("FAIL reset_node[%0d] got %h %h %h %h want 0", i, pos_x[i], pos_y[i], vel_x[i], vel_y[i]);
            end
        end
        m_cnt = 0; m_err = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || step_cnt !== 16'd0 || terr !== 1'b0 ||
            cif.coll_begin_out !== 1'b0 || cif.coll_pos_x_out !== '0 || cif.coll_vel_y_out !== '0) begin
            bad++; $display("FAIL reset_status got busy=%b done=%b cnt=%0d err=%b beg=%b want all 0",
                            busy, done, step_cnt, terr, cif.coll_begin_out);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int b;
        write_node(0, 10, 20, 3, 0);
        for (int i = 0; i < int'(N); i++) begin
            dly[i] = 2; rnx[i] = m_px[i]; rny[i] = m_py[i]; rvx[i] = m_vx[i];
            rvy[i] = sat(m_vy[i] + GRAV); rax[i] = 0; ray[i] = 0;
        end
        b = issue_total;
        run_step(1'b0, 0, 0, 0, 0, 0, 1'b0);
        total++;
        if (lg_vy.size() <= b || lg_vy[b] !== -1) begin bad++; $display("FAIL basic_issue_vy want -1"); end
        total++;
        if (s8(pos_x[0]) !== 10 || s8(pos_y[0]) !== 20 || s8(vel_x[0]) !== 3 || s8(vel_y[0]) !== -1) begin
            bad++; $display("FAIL basic_node0 got (%0d,%0d,%0d,%0d) want (10,20,3,-1)",
                            s8(pos_x[0]), s8(pos_y[0]), s8(vel_x[0]), s8(vel_y[0]));
        end
    endtask

    task automatic test_saturation();
        int b;
        write_node(1, rnd8(), rnd8(), rnd8(), -128);
        random_resp(5);
        rvx[1] = 126; rax[1] = 3; rvy[1] = -127; ray[1] = -4;
        b = issue_total;
        run_step(1'b0, 0, 0, 0, 0, 0, 1'b0);
        total++;
        if (lg_vy.size() <= b + 1 || lg_vy[b+1] !== -128) begin bad++; $display("FAIL sat_issue_vy want -128"); end
        total++;
        if (s8(vel_x[1]) !== 127 || s8(vel_y[1]) !== -128) begin
            bad++; $display("FAIL sat_store got (%0d,%0d) want (127,-128)", s8(vel_x[1]), s8(vel_y[1]));
        end
    endtask

    task automatic test_same_cycle_write_begin();
        int b;
        random_resp(4);
        b = issue_total;
        run_step(1'b1, 0, 5, 5, 7, -3, 1'b0);
        total++;
        if (lg_px.size() <= b || lg_px[b] !== 5 || lg_py[b] !== 5) begin
            bad++; $display("FAIL wr_begin_issue want coll_pos=(5,5)");
        end
    endtask

    task automatic test_ignored_inputs();
        write_node(6, 1, 2, 3, 4);
        for (int k = 0; k < 3; k++) begin
            random_resp(6);
            run_step(1'b0, 0, 0, 0, 0, 0, 1'b1);
        end
    endtask

    task automatic test_timeout();
        random_resp(3);
        dly[0] = 3; dly[1] = 1; dly[2] = 0; dly[3] = 64; dly[4] = 65;
        run_step(1'b0, 0, 0, 0, 0, 0, 1'b0);
        total++;
        if (terr !== 1'b1) begin bad++; $display("FAIL timeout_flag got %b want 1", terr); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            random_resp(8);
            run_step(1'b0, 0, 0, 0, 0, 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_step();
        int b, waited;
        random_resp(2);
        dly[0] = 2; dly[1] = 12;
        b = issue_total;
        step_base = issue_total;
        begin_in = 1'b1;
        @(negedge clk);
        begin_in = 1'b0;
        waited = 0;
        while (issue_total - b < 2 && waited < 200) begin @(negedge clk); waited++; end
        total++;
        if (issue_total - b < 2) begin bad++; $display("FAIL reach_node1 got %0d issues want 2", issue_total - b); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        for (int i = 0; i < int'(N); i++) begin
            m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
            total++;
            if (pos_x[i] !== '0 || pos_y[i] !== '0 || vel_x[i] !== '0 || vel_y[i] !== '0) begin
                bad++; $display("FAIL midreset_node[%0d] got %h %h %h %h want 0", i, pos_x[i], pos_y[i], vel_x[i], vel_y[i]);
            end
        end
        m_cnt = 0; m_err = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || step_cnt !== 16'd0 || terr !== 1'b0 ||
            cif.coll_begin_out !== 1'b0 || cif.coll_pos_y_out !== '0 || cif.coll_vel_x_out !== '0) begin
            bad++; $display("FAIL midreset_status got busy=%b done=%b cnt=%0d err=%b want all 0", busy, done, step_cnt, terr);
        end
        total++;
        if (issue_total - b !== 2) begin bad++; $display("FAIL midreset_issues got %0d want 2", issue_total - b); end
    endtask

    task automatic test_after_reset();
        for (int i = 0; i < int'(N); i++) write_node(i, rnd8(), rnd8(), rnd8(), rnd8());
        random_resp(6);
        run_step(1'b0, 0, 0, 0, 0, 0, 1'b1);
    endtask

    initial begin
        rst = 1'b0; begin_in = 1'b0; wr_en = 1'b0; wr_idx = '0;
        wr_px = '0; wr_py = '0; wr_vx = '0; wr_vy = '0;
        for (int i = 0; i < int'(N); i++) begin
            dly[i] = 1; rnx[i] = 0; rny[i] = 0; rvx[i] = 0; rvy[i] = 0; rax[i] = 0; ray[i] = 0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturation();
        test_same_cycle_write_begin();
        test_ignored_inputs();
        test_timeout();
        test_back_to_back();
        test_reset_mid_step();
        test_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/node_step_sequencer.md
Name: node_step_sequencer

Overview:
- Owns the position/velocity state of every point-mass node of the squishy car and runs one physics step per begin_in.
- Per step, walks nodes 0..NUM_NODES-1 in order:
  - applies gravity to the node's velocity;
  - hands the node to the collision stage over a begin/result handshake;
  - folds the returned position, velocity and acceleration back into the node array.
- Sits directly upstream of the collision stage (feeds it) and downstream of it (consumes its results).

Parameters:
- NUM_NODES, 8, number of car nodes (>=1).
- POSITION_SIZE, 8, signed position width.
- VELOCITY_SIZE, 8, signed velocity width.
- ACCELERATION_SIZE, 3, signed acceleration width from the collision stage.
- GRAVITY, -1, signed constant added to vel_y before each node is issued.
- TIMEOUT, 64, maximum WAIT cycles before a node is abandoned.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-low reset.
- begin_in  in  1  start one step; sampled only in IDLE.
- wr_en_in  in  1  node write strobe; honoured only in IDLE.
- wr_idx_in  in  $clog2(NUM_NODES)  node to write.
- wr_pos_x_in, wr_pos_y_in  in  POSITION_SIZE each  write data.
- wr_vel_x_in, wr_vel_y_in  in  VELOCITY_SIZE each  write data.
- coll_begin_out  out  1  one-cycle start pulse to the collision stage.
- coll_pos_x_out, coll_pos_y_out  out  POSITION_SIZE each  node position issued.
- coll_vel_x_out, coll_vel_y_out  out  VELOCITY_SIZE each  node velocity issued, gravity applied.
- coll_result_in  in  1  one-cycle done pulse from the collision stage.
- coll_new_pos_x_in, coll_new_pos_y_in  in  POSITION_SIZE each  returned position.
- coll_new_vel_x_in, coll_new_vel_y_in  in  VELOCITY_SIZE each  returned velocity.
- coll_acc_x_in, coll_acc_y_in  in  ACCELERATION_SIZE each  returned acceleration.
- pos_x_out, pos_y_out  out  POSITION_SIZE x NUM_NODES  node positions.
- vel_x_out, vel_y_out  out  VELOCITY_SIZE x NUM_NODES  node velocities.
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse at end of step.
- step_count_out  out  16  completed steps; wraps at 0xFFFF -> 0.
- timeout_err_out  out  1  sticky; set when any node times out; cleared only by reset.

Behaviour:
- Reset (rst_in==0 at clk edge), including mid-step:
  - state -> IDLE;
  - all node pos/vel registers, coll_* outputs, done_out, busy_out, step_count_out, timeout_err_out -> 0;
  - any outstanding collision result is ignored.
- IDLE:
  - wr_en_in writes all four fields of node wr_idx_in at the clock edge; wr_idx_in >= NUM_NODES is ignored.
  - On begin_in: node index <= 0, go to ISSUE.
  - Write and begin in the same cycle: the write commits, and the step uses the written value.
- ISSUE (1 cycle):
  - drive coll_pos_* = node pos;
  - coll_vel_x = vel_x;
  - coll_vel_y = sat(vel_y + GRAVITY);
  - pulse coll_begin_out;
  - clear the wait counter; go to WAIT.
  - coll_* outputs are held stable until the next ISSUE.
- WAIT:
  - On coll_result_in: capture all returned fields, go to WRITEBACK.
  - Otherwise the counter increments.
  - If the counter reaches TIMEOUT with no result:
    - node is left unchanged;
    - timeout_err_out <= 1;
    - go to ADVANCE.
  - If the result and the timeout land in the same cycle, the result wins.
- WRITEBACK (1 cycle):
  - pos <= captured new_pos;
  - vel_x <= sat(new_vel_x + sign-extended acc_x); vel_y likewise;
  - go to ADVANCE.
- ADVANCE (1 cycle):
  - if index == NUM_NODES-1, go to DONE;
  - else index++ and go to ISSUE.
- DONE (1 cycle): done_out=1, step_count_out++, go to IDLE.
- sat(): computed at VELOCITY_SIZE+1 bits, clamped to [-2^(V-1), 2^(V-1)-1]. Positions are taken as returned, with no clamp.
- Latency per node, result k cycles after begin (k>=1): 3+k cycles. Full step = sum over nodes + 1 (DONE).
- Ignored inputs:
  - begin_in and wr_en_in while busy are ignored; nothing is queued.
  - coll_result_in outside WAIT is ignored.

Test Plan:
- Write node0 pos=(10,20) vel=(3,0); NUM_NODES=1; begin; collision model echoes coll_* inputs with acc=0 after 2 cycles -> coll_vel_y_out=-1; final vel=(3,-1), pos=(10,20); done_out pulses once; step_count_out=1.
- Node vel_y=-128 with GRAVITY=-1 -> coll_vel_y_out=-128 (saturated). Returned vel_x=126 with acc_x=+3 -> stored vel_x=127.
- NUM_NODES=4, model returns pos+1 per node -> coll_begin_out pulses exactly 4 times in index order; each stored pos is incremented; done_out pulses after the 4th ADVANCE.
- Model never answers node 2 -> after 64 WAIT cycles timeout_err_out=1; node 2 unchanged; nodes 0,1,3 updated; done_out still pulses.
- Assert rst_in=0 while in WAIT of node 1, then send a late coll_result_in pulse -> all outputs 0; state IDLE; the late pulse does not modify any node.
- In IDLE assert begin_in and wr_en_in(idx0, pos=(5,5)) in the same cycle -> ISSUE drives coll_pos=(5,5). A begin_in pulse mid-step is ignored (step_count_out increments by 1 only).
